// File: rtl/input_2.sv
// input_2: registered two-element sorter carrying labels, stable on ties.
// Define INPUT_2_INREG_EN to add an input register stage (latency 2 instead of 1).
module input_2 #(
    parameter int DATA_WIDTH  = 8,
    parameter int LABEL_WIDTH = 1,
    parameter int SIGNED      = 1,
    parameter int ASCENDING   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   x_valid,
    input  logic [DATA_WIDTH-1:0]  x_0,
    input  logic [DATA_WIDTH-1:0]  x_1,
    input  logic [LABEL_WIDTH-1:0] x_label_0,
    input  logic [LABEL_WIDTH-1:0] x_label_1,
    output logic [DATA_WIDTH-1:0]  y_0,
    output logic [DATA_WIDTH-1:0]  y_1,
    output logic [LABEL_WIDTH-1:0] y_label_0,
    output logic [LABEL_WIDTH-1:0] y_label_1,
    output logic                   y_valid
);
    logic                   a_valid;
    logic [DATA_WIDTH-1:0]  a_0, a_1;
    logic [LABEL_WIDTH-1:0] a_l0, a_l1;
`ifdef INPUT_2_INREG_EN
    logic                   a_valid_q;
    logic [DATA_WIDTH-1:0]  a0_q, a1_q;
    logic [LABEL_WIDTH-1:0] al0_q, al1_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_q <= 1'b0;
            a0_q      <= '0;
            a1_q      <= '0;
            al0_q     <= '0;
            al1_q     <= '0;
        end else begin
            a_valid_q <= x_valid;
            a0_q      <= x_0;
            a1_q      <= x_1;
            al0_q     <= x_label_0;
            al1_q     <= x_label_1;
        end
    end
    assign a_valid = a_valid_q;
    assign a_0     = a0_q;
    assign a_1     = a1_q;
    assign a_l0    = al0_q;
    assign a_l1    = al1_q;
`else
    assign a_valid = x_valid;
    assign a_0     = x_0;
    assign a_1     = x_1;
    assign a_l0    = x_label_0;
    assign a_l1    = x_label_1;
`endif
    logic                   gt, lt, swap;
    logic [DATA_WIDTH-1:0]  y0_q, y1_q, y0_d, y1_d;
    logic [LABEL_WIDTH-1:0] yl0_q, yl1_q, yl0_d, yl1_d;
    logic                   yv_q;
    // Strict compares only, so equal words never swap and the sort stays stable
    always_comb begin
        gt    = (SIGNED != 0) ? ($signed(a_0) > $signed(a_1)) : (a_0 > a_1);
        lt    = (SIGNED != 0) ? ($signed(a_0) < $signed(a_1)) : (a_0 < a_1);
        swap  = (ASCENDING != 0) ? gt : lt;
        y0_d  = a_valid ? (swap ? a_1 : a_0) : y0_q;
        y1_d  = a_valid ? (swap ? a_0 : a_1) : y1_q;
        yl0_d = a_valid ? (swap ? a_l1 : a_l0) : yl0_q;
        yl1_d = a_valid ? (swap ? a_l0 : a_l1) : yl1_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            yv_q  <= 1'b0;
            y0_q  <= '0;
            y1_q  <= '0;
            yl0_q <= '0;
            yl1_q <= '0;
        end else begin
            yv_q  <= a_valid;
            y0_q  <= y0_d;
            y1_q  <= y1_d;
            yl0_q <= yl0_d;
            yl1_q <= yl1_d;
        end
    end
    assign y_valid   = yv_q;
    assign y_0       = y0_q;
    assign y_1       = y1_q;
    assign y_label_0 = yl0_q;
    assign y_label_1 = yl1_q;
endmodule

// File: tb/tb_input_2.sv
// tb_input_2: scoreboard bench driving four SIGNED/ASCENDING variants of input_2 in parallel.
module tb_input_2;
`ifdef INPUT_2_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x_valid = 1'b0;
    logic [7:0] x_0 = '0, x_1 = '0;
    logic       x_label_0 = 1'b0, x_label_1 = 1'b0;
    logic [7:0] y0 [4];
    logic [7:0] y1 [4];
    logic       yl0 [4];
    logic       yl1 [4];
    logic       yv [4];
    logic [18:0] obs [4];
    logic [18:0] q [4][$];
    logic [17:0] hold [4];
    int n_run = 0, n_fail = 0;

    always #5 clk = ~clk;

    // u0: signed/asc, u1: unsigned/asc, u2: signed/desc, u3: unsigned/desc
    for (genvar g = 0; g < 4; g++) begin : g_dut
        input_2 #(.DATA_WIDTH(8), .LABEL_WIDTH(1), .SIGNED(1 - g % 2), .ASCENDING(1 - g / 2)) u_dut (
            .clk(clk), .rst(rst), .x_valid(x_valid),
            .x_0(x_0), .x_1(x_1), .x_label_0(x_label_0), .x_label_1(x_label_1),
            .y_0(y0[g]), .y_1(y1[g]), .y_label_0(yl0[g]), .y_label_1(yl1[g]), .y_valid(yv[g])
        );
        assign obs[g] = {yv[g], y0[g], y1[g], yl0[g], yl1[g]};
    end

    task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got v=%b y0=%h y1=%h l0=%b l1=%b exp v=%b y0=%h y1=%h l0=%b l1=%b",
                     tag, got[18], got[17:10], got[9:2], got[1], got[0],
                     exp[18], exp[17:10], exp[9:2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [17:0] model(int k, logic [7:0] a, logic [7:0] b, logic la, logic lb);
        int va, vb;
        logic sw;
        va = (k % 2 == 0) ? int'($signed(a)) : int'(a);
        vb = (k % 2 == 0) ? int'($signed(b)) : int'(b);
        sw = (k / 2 == 0) ? (va > vb) : (vb > va);
        return sw ? {b, a, lb, la} : {a, b, la, lb};
    endfunction

    task automatic clr();
        for (int k = 0; k < 4; k++) begin
            q[k].delete();
            hold[k] = '0;
            repeat (LAT - 1) q[k].push_back('0);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic la, input logic lb);
        logic [18:0] e;
        @(negedge clk);
        rst = 1'b0;
        x_valid = v; x_0 = a; x_1 = b; x_label_0 = la; x_label_1 = lb;
        for (int k = 0; k < 4; k++) begin
            if (v) hold[k] = model(k, a, b, la, lb);
            q[k].push_back({v, hold[k]});
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            e = q[k].pop_front();
            check($sformatf("u%0d_out", k), obs[k], e);
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        x_valid = 1'b1; x_0 = 8'h12; x_1 = 8'h34;
        #1;
        for (int k = 0; k < 4; k++) check($sformatf("u%0d_rst_async", k), obs[k], '0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) check($sformatf("u%0d_rst_hold", k), obs[k], '0);
        x_valid = 1'b0;
        clr();
    endtask

    initial begin
        clr();
        #1;
        for (int k = 0; k < 4; k++) check($sformatf("u%0d_reset", k), obs[k], '0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) check($sformatf("u%0d_reset_clk", k), obs[k], '0);
        step(1, 8'h05, 8'hFB, 1'b0, 1'b1);
        step(1, 8'h80, 8'h7F, 1'b0, 1'b1);
        step(1, 8'h33, 8'h33, 1'b1, 1'b0);
        step(1, 8'h7F, 8'h80, 1'b1, 1'b0);
        step(1, 8'h00, 8'hFF, 1'b0, 1'b1);
        step(1, $urandom, $urandom, $urandom, $urandom);
        step(1, $urandom, $urandom, $urandom, $urandom);
        step(0, $urandom, $urandom, $urandom, $urandom);
        step(1, $urandom, $urandom, $urandom, $urandom);
        for (int i = 0; i < 30; i++)
            step(($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom, $urandom);
        step(1, 8'h11, 8'h22, 1'b1, 1'b0);
        reset_pulse();
        step(1, 8'hFB, 8'h05, 1'b1, 1'b0);
        step(0, 8'h00, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++)
            step(($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom, $urandom);
        step(1, 8'h44, 8'h44, 1'b0, 1'b1);
        reset_pulse();
        repeat (LAT + 1) step(0, 8'h00, 8'h00, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
